// File: rtl/binary_counter_mod_if.sv
// Control/status bundle for binary_counter_mod: the master drives the count controls,
// and the slave (the counter) returns count and status.
interface binary_counter_mod_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up_dn, load, load_val, ovf_clr,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  en, up_dn, load, load_val, ovf_clr,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/binary_counter_mod.sv
// Parametrised up/down modulo counter with clamped parallel load, terminal count, wrap pulse and sticky overflow.
// Defining BINARY_COUNTER_SAT_EN makes the counter saturate at its range limits instead of wrapping.
module binary_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_counter_mod_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             ovf_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             ovf_nxt_s;
    logic             at_max_s;
    logic             at_min_s;
    logic             tc_s;
    logic             wrap_evt_s;

    // Terminal count and wrap-event detection from registered state and live inputs
    always_comb begin
        at_max_s   = (count_r == MAX_C);
        at_min_s   = (count_r == ZERO_C);
        tc_s       = bus.en & ((bus.up_dn & at_max_s) | (~bus.up_dn & at_min_s));
        wrap_evt_s = tc_s & ~bus.load;
    end

    // Next-count selection: load (clamped) beats counting, counting beats hold
    always_comb begin
        count_nxt_s = count_r;
        if (bus.load) begin
            if (bus.load_val > MAX_C) begin
                count_nxt_s = MAX_C;
            end else begin
                count_nxt_s = bus.load_val;
            end
        end else if (bus.en) begin
            if (bus.up_dn) begin
`ifdef BINARY_COUNTER_SAT_EN
                count_nxt_s = at_max_s ? MAX_C : (count_r + ONE_C);
`else
                count_nxt_s = at_max_s ? ZERO_C : (count_r + ONE_C);
`endif
            end else begin
`ifdef BINARY_COUNTER_SAT_EN
                count_nxt_s = at_min_s ? ZERO_C : (count_r - ONE_C);
`else
                count_nxt_s = at_min_s ? MAX_C : (count_r - ONE_C);
`endif
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Sticky overflow: a wrap event in the same cycle as a clear keeps the flag set
    always_comb begin
        ovf_nxt_s = ovf_r;
        if (wrap_evt_s) begin
            ovf_nxt_s = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= ZERO_C;
            wrap_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_evt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    assign bus.count = count_r;
    assign bus.tc    = tc_s;
    assign bus.wrap  = wrap_r;
    assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_binary_counter_mod.sv
// Scoreboard bench: two counters (MODULUS 10 and 16) share stimulus; an integer reference model
// predicts each edge, and a monitor compares tc mid-cycle and count/wrap/ovf after each edge.
module tb_binary_counter_mod;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    binary_counter_mod_if #(.WIDTH(4)) bus10();
    binary_counter_mod_if #(.WIDTH(4)) bus16();

    binary_counter_mod #(.WIDTH(4), .MODULUS(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));
    binary_counter_mod #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit wrap;
        bit ovf;
    } mstate_t;

    typedef struct {
        bit chk_tc;
        bit tc10;
        bit tc16;
        mstate_t s10;
        mstate_t s16;
    } exp_t;

    exp_t    sb[$];
    mstate_t m10;
    mstate_t m16;
    bit      mvalid = 1'b0;

    function automatic bit model_tc(int m, int cnt, bit en, bit up);
        return en && ((up && cnt == m - 1) || (!up && cnt == 0));
    endfunction

    function automatic mstate_t model_next(int m, mstate_t cur, bit rst_ok, bit en, bit up,
                                           bit ld, int lv, bit clr);
        mstate_t n;
        bit      evt;
        evt = !ld && model_tc(m, cur.cnt, en, up);
        if (!rst_ok) begin
            n.cnt = 0;
            n.wrap = 1'b0;
            n.ovf = 1'b0;
        end else begin
            if (ld) n.cnt = (lv > m - 1) ? m - 1 : lv;
            else if (en) begin
`ifdef BINARY_COUNTER_SAT_EN
                if (up) n.cnt = (cur.cnt + 1 > m - 1) ? m - 1 : cur.cnt + 1;
                else    n.cnt = (cur.cnt - 1 < 0) ? 0 : cur.cnt - 1;
`else
                if (up) n.cnt = (cur.cnt + 1) % m;
                else    n.cnt = (cur.cnt + m - 1) % m;
`endif
            end else n.cnt = cur.cnt;
            n.wrap = evt;
            n.ovf  = evt || (cur.ovf && !clr);
        end
        return n;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: apply inputs to both counters and queue the model prediction
    task automatic drive(bit r, bit en, bit up, bit ld, int lv, bit clr);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus10.en = en; bus10.up_dn = up; bus10.load = ld; bus10.load_val = 4'(lv); bus10.ovf_clr = clr;
        bus16.en = en; bus16.up_dn = up; bus16.load = ld; bus16.load_val = 4'(lv); bus16.ovf_clr = clr;
        e.chk_tc = mvalid;
        e.tc10 = model_tc(10, m10.cnt, en, up);
        e.tc16 = model_tc(16, m16.cnt, en, up);
        m10 = model_next(10, m10, r, en, up, ld, lv, clr);
        m16 = model_next(16, m16, r, en, up, ld, lv, clr);
        if (!r) mvalid = 1'b1;
        e.s10 = m10;
        e.s16 = m16;
        sb.push_back(e);
    endtask

    task automatic run(int n, bit en, bit up);
        for (int i = 0; i < n; i++) drive(1'b1, en, up, 1'b0, 0, 1'b0);
    endtask

    // Monitor: tc checked while inputs are stable, registered outputs after each edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0 && sb[0].chk_tc) begin
                chk("tc10", 16'(bus10.tc), 16'(sb[0].tc10));
                chk("tc16", 16'(bus16.tc), 16'(sb[0].tc16));
            end
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count10", 16'(bus10.count), 16'(e.s10.cnt));
                chk("wrap10",  16'(bus10.wrap),  16'(e.s10.wrap));
                chk("ovf10",   16'(bus10.ovf),   16'(e.s10.ovf));
                chk("count16", 16'(bus16.count), 16'(e.s16.cnt));
                chk("wrap16",  16'(bus16.wrap),  16'(e.s16.wrap));
                chk("ovf16",   16'(bus16.ovf),   16'(e.s16.ovf));
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0;
        bus10.en = 1'b0; bus10.up_dn = 1'b1; bus10.load = 1'b0; bus10.load_val = 4'd0; bus10.ovf_clr = 1'b0;
        bus16.en = 1'b0; bus16.up_dn = 1'b1; bus16.load = 1'b0; bus16.load_val = 4'd0; bus16.ovf_clr = 1'b0;
        m10 = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};
        m16 = '{cnt: 0, wrap: 1'b0, ovf: 1'b0};

        // Reset dominates load and enable, then count up through the range
        drive(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 7, 1'b0);
        run(9, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);

        // Clamped load, down wrap from 0, load beats enable
        drive(1'b1, 1'b0, 1'b1, 1'b1, 12, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        run(2, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5, 1'b0);

        // Wrap and clear on the same edge, then direction change mid-run
        drive(1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        run(1, 1'b1, 1'b1);
        run(2, 1'b1, 1'b0);

        // Free run through natural rollover, then hold at 6
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        run(32, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0);
        run(3, 1'b0, 1'b1);

        // Sit at the range limits with enable held (saturating build holds here)
        drive(1'b1, 1'b0, 1'b1, 1'b1, 9, 1'b0);
        run(3, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        run(3, 1'b1, 1'b0);

        // Reset mid-load with clear asserted
        drive(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31, 0) != 0),
                  ($urandom_range(3, 0) != 0),
                  1'($urandom_range(1, 0)),
                  ($urandom_range(7, 0) == 0),
                  $urandom_range(15, 0),
                  ($urandom_range(7, 0) == 0));
        end

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
